fwft_fifo_param: RTL and testbench

Parametrised first-word-fall-through FIFO. It is the next-generation buffer for the merge-tree datapath, replacing the fixed-depth shift-register and pointer FIFOs. It adds:
- configurable width and depth
- a true occupancy count
- programmable almost-full and almost-empty flags
- sticky overrun/underrun error flags
- synchronous flush

It sits between merger stages as the per-lane elastic buffer that backpressures upstream via o_almost_full.

---
 rtl/fwft_fifo_param_pkg.sv | 21 ++
 rtl/fwft_fifo_param_if.sv | 30 +++
 rtl/fwft_fifo_param_ram.sv | 20 ++
 rtl/fwft_fifo_param.sv | 108 ++++++++++
 tb/tb_fwft_fifo_param.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/fwft_fifo_param_pkg.sv
// Shared sizing helpers and threshold legality checks for the FWFT FIFO family.
package bonsai_fifo_pkg;

  localparam int DEF_DEPTH_LOG = 4;
  localparam int DEF_AEMPTY    = 1;

  function automatic int fifo_depth(input int depth_log);
    return 1 << depth_log;
  endfunction

  function automatic int default_afull(input int depth_log);
    return fifo_depth(depth_log) - 2;
  endfunction

  function automatic bit thresholds_ok(input int depth_log, input int afull, input int aempty);
    return (depth_log >= 1) && (depth_log <= 10) &&
           (afull >= 1) && (afull <= fifo_depth(depth_log)) &&
           (aempty >= 0) && (aempty < fifo_depth(depth_log));
  endfunction

endpackage

// File: rtl/fwft_fifo_param_if.sv
// Handshake, data and status bundle between a FIFO and the stage driving it.
interface fwft_fifo_if #(
  parameter int P_WIDTH     = 32,
  parameter int P_DEPTH_LOG = 4
);
  logic                   i_clear;
  logic [P_WIDTH-1:0]     i_data;
  logic                   i_enq;
  logic                   i_deq;
  logic [P_WIDTH-1:0]     o_data;
  logic                   o_full;
  logic                   o_empty;
  logic                   o_almost_full;
  logic                   o_almost_empty;
  logic [P_DEPTH_LOG:0]   o_count;
  logic                   o_overrun;
  logic                   o_underrun;

  modport slave (
    input  i_clear, i_data, i_enq, i_deq,
    output o_data, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overrun, o_underrun
  );

  modport master (
    output i_clear, i_data, i_enq, i_deq,
    input  o_data, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overrun, o_underrun
  );
endinterface

// File: rtl/fwft_fifo_param_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_ram_sdp #(
  parameter int P_WIDTH     = 32,
  parameter int P_DEPTH_LOG = 4
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [P_DEPTH_LOG-1:0] waddr_i,
  input  logic [P_WIDTH-1:0]     wdata_i,
  input  logic [P_DEPTH_LOG-1:0] raddr_i,
  output logic [P_WIDTH-1:0]     rdata_o
);
  logic [P_WIDTH-1:0] mem_q [0:(1<<P_DEPTH_LOG)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fwft_fifo_param.sv
// First-word-fall-through FIFO with registered head, occupancy count,
// programmable almost flags and sticky overrun/underrun.
module fwft_fifo_param
  import bonsai_fifo_pkg::*;
#(
  parameter int P_WIDTH     = 32,
  parameter int P_DEPTH_LOG = DEF_DEPTH_LOG,
  parameter int P_AFULL     = default_afull(P_DEPTH_LOG),
  parameter int P_AEMPTY    = DEF_AEMPTY
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  fwft_fifo_if.slave bus
);
  localparam int                   D        = fifo_depth(P_DEPTH_LOG);
  localparam int                   CW       = P_DEPTH_LOG + 1;
  localparam logic [CW-1:0]        DEPTH_C  = CW'(D);
  localparam logic [CW-1:0]        AFULL_C  = CW'(P_AFULL);
  localparam logic [CW-1:0]        AEMPTY_C = CW'(P_AEMPTY);
  localparam logic [CW-1:0]        ONE_C    = CW'(1);

  if (!thresholds_ok(P_DEPTH_LOG, P_AFULL, P_AEMPTY)) begin : g_param_check
    $error("fwft_fifo_param: illegal P_DEPTH_LOG/P_AFULL/P_AEMPTY combination");
  end

  logic [P_DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CW-1:0]          count_q, count_d;
  logic [P_WIDTH-1:0]     head_q, head_d, ram_rdata;
  logic                   full_q, empty_q, afull_q, aempty_q;
  logic                   ovr_q, ovr_d, und_q, und_d;
  logic                   wr_ok, rd_ok, ram_we;

  fifo_ram_sdp #(
    .P_WIDTH     (P_WIDTH),
    .P_DEPTH_LOG (P_DEPTH_LOG)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.i_data),
    .raddr_i (rd_next),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ok    = bus.i_enq & (~full_q | bus.i_deq);
    rd_ok    = bus.i_deq & ~empty_q;
    rd_next  = rd_ptr_q + P_DEPTH_LOG'(1);
    ram_we   = wr_ok & ~bus.i_clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    ovr_d    = ovr_q;
    und_d    = und_q;
    if (bus.i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovr_d    = 1'b0;
      und_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + P_DEPTH_LOG'(1);
      if (rd_ok) rd_ptr_d = rd_next;
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
      if (bus.i_enq & full_q & ~bus.i_deq) ovr_d = 1'b1;
      if (bus.i_deq & empty_q) und_d = 1'b1;
      // Incoming word becomes head when nothing else will be left to show.
      if (wr_ok && (count_q == CW'(rd_ok))) head_d = bus.i_data;
      else if (rd_ok && (count_q > ONE_C)) head_d = ram_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AFULL_C == '0);
      aempty_q <= 1'b1;
      ovr_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AFULL_C);
      aempty_q <= (count_d <= AEMPTY_C);
      ovr_q    <= ovr_d;
      und_q    <= und_d;
    end
  end

  assign bus.o_data         = head_q;
  assign bus.o_count        = count_q;
  assign bus.o_full         = full_q;
  assign bus.o_empty        = empty_q;
  assign bus.o_almost_full  = afull_q;
  assign bus.o_almost_empty = aempty_q;
  assign bus.o_overrun      = ovr_q;
  assign bus.o_underrun     = und_q;
endmodule

// File: tb/tb_fwft_fifo_param.sv
// Scoreboard bench: queue-based reference model predicts every post-edge state,
// a negedge monitor compares the DUT outputs against the predictions.
module tb_fwft_fifo_param;
  localparam int W  = 32;
  localparam int DL = 4;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 1;

  typedef struct {
    logic [W-1:0] data;
    logic [DL:0]  count;
    logic         full, empty, af, ae, ov, un;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fwft_fifo_if #(.P_WIDTH(W), .P_DEPTH_LOG(DL)) bus ();

  fwft_fifo_param #(.P_WIDTH(W), .P_DEPTH_LOG(DL)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  exp_t exp_q[$];

  logic [W-1:0] mq[$];
  logic [W-1:0] m_hd = '0;
  bit m_ov = 0, m_un = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic exp_t model_view();
    exp_t e;
    int n = mq.size();
    e.data  = m_hd;
    e.count = (DL+1)'(n);
    e.full  = (n == D);
    e.empty = (n == 0);
    e.af    = (n >= AF);
    e.ae    = (n <= AE);
    e.ov    = m_ov;
    e.un    = m_un;
    return e;
  endfunction

  task automatic model_step(input bit clr, input bit en, input bit de, input logic [W-1:0] d);
    bit full, empty, wr, rd;
    if (clr) begin
      mq.delete();
      m_ov = 0;
      m_un = 0;
      return;
    end
    full  = (mq.size() == D);
    empty = (mq.size() == 0);
    wr = en && (!full || de);
    rd = de && !empty;
    if (de && empty) m_un = 1;
    if (en && full && !de) m_ov = 1;
    if (rd) void'(mq.pop_front());
    if (wr) mq.push_back(d);
    if (mq.size() > 0) m_hd = mq[0];
  endtask

  task automatic model_reset();
    mq.delete();
    m_hd = '0;
    m_ov = 0;
    m_un = 0;
  endtask

  task automatic step(input bit clr, input bit en, input bit de, input logic [W-1:0] d);
    bus.i_clear = clr;
    bus.i_enq   = en;
    bus.i_deq   = de;
    bus.i_data  = d;
    @(posedge clk);
    model_step(clr, en, de, d);
    exp_q.push_back(model_view());
    #2;
    bus.i_clear = 1'b0;
    bus.i_enq   = 1'b0;
    bus.i_deq   = 1'b0;
  endtask

  task automatic chk_direct(input string tag, input exp_t e);
    chk({tag, "_count"}, W'(bus.o_count), W'(e.count));
    chk({tag, "_data"},  bus.o_data, e.data);
    chk({tag, "_full"},  W'(bus.o_full), W'(e.full));
    chk({tag, "_empty"}, W'(bus.o_empty), W'(e.empty));
    chk({tag, "_afull"}, W'(bus.o_almost_full), W'(e.af));
    chk({tag, "_aempty"},W'(bus.o_almost_empty), W'(e.ae));
    chk({tag, "_ovr"},   W'(bus.o_overrun), W'(e.ov));
    chk({tag, "_und"},   W'(bus.o_underrun), W'(e.un));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk_direct("mon", e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_clear = 1'b0;
    bus.i_enq   = 1'b0;
    bus.i_deq   = 1'b0;
    bus.i_data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_direct("reset", model_view());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    repeat (3) step(0, 0, 0, '0);

    // fill A0..AF, then overrun attempt
    for (int i = 0; i < D; i++) step(0, 1, 0, W'(32'hA0 + i));
    step(0, 1, 0, 32'hFF);

    // drain and one extra deq for underrun
    for (int i = 0; i <= D; i++) step(0, 0, 1, '0);

    // refill then simultaneous enq+deq while full across pointer wrap
    step(1, 0, 0, '0);
    for (int i = 0; i < D; i++) step(0, 1, 0, W'($urandom));
    for (int i = 0; i < 20; i++) step(0, 1, 1, W'(32'hB0 + i));
    for (int i = 0; i < D; i++) step(0, 0, 1, '0);

    // empty enq+deq same cycle
    step(1, 0, 0, '0);
    step(0, 1, 1, 32'h55);
    step(0, 0, 1, '0);

    // clear with enq at count 7
    step(0, 0, 1, '0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, W'(32'hC0 + i));
    step(1, 1, 0, 32'hEE);
    step(0, 1, 0, 32'hD0);
    step(0, 0, 1, '0);

    // randomized traffic with alternating fill/drain bias and rare clears
    for (int i = 0; i < 400; i++) begin
      int p;
      p = ((i / 40) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < p),
           ($urandom_range(0, 99) >= p), W'($urandom));
    end

    // asynchronous reset in the middle of a burst, with sticky flag set
    step(1, 0, 0, '0);
    for (int i = 0; i < D; i++) step(0, 1, 0, W'($urandom));
    step(0, 1, 0, 32'h77);
    for (int i = 0; i < 3; i++) step(0, 1, 1, W'($urandom));
    @(negedge clk);
    #1;
    bus.i_enq  = 1'b1;
    bus.i_data = 32'h99;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_direct("async_rst", model_view());
    bus.i_enq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    step(0, 1, 0, 32'h42);
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
